// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with registered, bypassed read
// ports and a one-register-per-cycle init sweep sequencer.
module regfile_param #(
    parameter int               WIDTH      = 4,
    parameter int               DEPTH      = 8,
    parameter int               ADDR_W     = 3,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              CLK,
    input  logic              CLRN,
    input  logic [ADDR_W-1:0] RP,
    input  logic [ADDR_W-1:0] RQ,
    input  logic [ADDR_W-1:0] WA,
    input  logic              WR,
    input  logic [WIDTH-1:0]  LD_DATA,
    input  logic              INIT,
    output logic [WIDTH-1:0]  DATAP,
    output logic [WIDTH-1:0]  DATAQ,
    output logic              BUSY,
    output logic              STATE_DBG
);

    // Interface timing: RP/RQ are accepted on every rising edge with no
    // back-pressure; DATAP/DATAQ hold the bypassed read one edge later.
    // BUSY high means WR/WA/LD_DATA are ignored and INIT is not sampled.

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              we;
    logic [ADDR_W-1:0] wa_eff;
    logic [WIDTH-1:0]  wd_eff;
    logic [WIDTH-1:0]  rd_p;
    logic [WIDTH-1:0]  rd_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        we        = 1'b0;
        wa_eff    = WA;
        wd_eff    = LD_DATA;
        case (state)
            IDLE: begin
                we = WR && in_range(WA);
                if (INIT) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                we     = 1'b1;
                wa_eff = ptr;
                wd_eff = INIT_VALUE;
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // The write landing on this edge wins over the stored value, so a read
    // issued alongside a write to the same address returns the new data.
    always_comb begin
        rd_p = '0;
        rd_q = '0;
        if (we && (wa_eff == RP)) begin
            rd_p = wd_eff;
        end else if (in_range(RP)) begin
            rd_p = mem[RP];
        end
        if (we && (wa_eff == RQ)) begin
            rd_q = wd_eff;
        end else if (in_range(RQ)) begin
            rd_q = mem[RQ];
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
            ptr   <= '0;
            DATAP <= '0;
            DATAQ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            DATAP <= rd_p;
            DATAQ <= rd_q;
            if (we) begin
                mem[wa_eff] <= wd_eff;
            end
        end
    end

    assign BUSY      = (state == SWEEP);
    assign STATE_DBG = state;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: an 8-register 4-bit instance and a 6-register 8-bit
// instance driven by directed vectors, checked through an expected-value queue.
module tb_regfile_param;

    localparam int EW = 27;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [2:0] rp = '0;
    logic [2:0] rq = '0;
    logic [2:0] wa = '0;
    logic       wr = 1'b0;
    logic [7:0] ld = '0;
    logic       init = 1'b0;
    logic       sel = 1'b0;

    logic [3:0] a_datap, a_dataq;
    logic       a_busy, a_state;
    logic [7:0] b_datap, b_dataq;
    logic       b_busy, b_state;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    tag_n = 8'd0;
    int            total = 0;
    int            bad = 0;

    regfile_param #(.WIDTH(4), .DEPTH(8), .ADDR_W(3), .INIT_VALUE(4'hA)) dut_a (
        .CLK(clk), .CLRN(clrn), .RP(rp), .RQ(rq), .WA(wa), .WR(wr),
        .LD_DATA(ld[3:0]), .INIT(init), .DATAP(a_datap), .DATAQ(a_dataq),
        .BUSY(a_busy), .STATE_DBG(a_state)
    );

    regfile_param #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .INIT_VALUE(8'hA5)) dut_b (
        .CLK(clk), .CLRN(clrn), .RP(rp), .RQ(rq), .WA(wa), .WR(wr),
        .LD_DATA(ld), .INIT(init), .DATAP(b_datap), .DATAQ(b_dataq),
        .BUSY(b_busy), .STATE_DBG(b_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string nm, input logic [7:0] tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h want %h", nm, tag, act, exp);
        end
    endtask

    // driver
    task automatic expect_out(input logic chk, input logic [7:0] ep, input logic [7:0] eq, input logic eb);
        exp_q.push_back({chk, sel, eb, ep, eq, tag_n});
        tag_n = tag_n + 8'd1;
    endtask

    task automatic step(input logic [2:0] rp_v, input logic [2:0] rq_v, input logic [2:0] wa_v,
                        input logic wr_v, input logic [7:0] d_v, input logic init_v,
                        input logic chk, input logic [7:0] ep, input logic [7:0] eq, input logic eb);
        @(negedge clk);
        rp   = rp_v;
        rq   = rq_v;
        wa   = wa_v;
        wr   = wr_v;
        ld   = d_v;
        init = init_v;
        expect_out(chk, ep, eq, eb);
    endtask

    // monitor: outputs sampled 1 time unit after each rising edge
    initial begin
        logic [EW-1:0] e;
        logic [7:0]    ap, aq;
        logic          ab, as;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e[26]) begin
                    if (e[25]) begin
                        ap = b_datap; aq = b_dataq; ab = b_busy; as = b_state;
                    end else begin
                        ap = {4'h0, a_datap}; aq = {4'h0, a_dataq}; ab = a_busy; as = a_state;
                    end
                    cmp("datap", e[7:0], ap, e[23:16]);
                    cmp("dataq", e[7:0], aq, e[15:8]);
                    cmp("busy", e[7:0], {7'd0, ab}, {7'd0, e[24]});
                    cmp("state", e[7:0], {7'd0, as}, {7'd0, e[24]});
                end
            end
        end
    end

    // stimulus
    initial begin
        #12;
        cmp("rst_a_p", 8'hF0, {4'h0, a_datap}, 8'h00);
        cmp("rst_a_busy", 8'hF1, {7'd0, a_busy}, 8'h00);
        cmp("rst_b_q", 8'hF2, b_dataq, 8'h00);
        cmp("rst_b_state", 8'hF3, {7'd0, b_state}, 8'h00);
        @(negedge clk);
        clrn = 1'b1;

        // write reg3/reg6, read back, others zero
        step(0, 0, 3, 1, 8'h05, 0, 0, 8'h00, 8'h00, 0);
        step(0, 0, 6, 1, 8'h0C, 0, 0, 8'h00, 8'h00, 0);
        step(3, 6, 0, 0, 8'h00, 0, 1, 8'h05, 8'h0C, 0);
        step(0, 1, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0);
        step(2, 4, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0);
        step(5, 7, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0);

        // same-cycle bypass on both ports
        step(0, 0, 2, 1, 8'h01, 0, 0, 8'h00, 8'h00, 0);
        step(2, 2, 2, 1, 8'h09, 0, 1, 8'h09, 8'h09, 0);
        step(2, 2, 0, 0, 8'h00, 0, 1, 8'h09, 8'h09, 0);

        // sweep with RP=RQ=4 held; WR during BUSY ignored; INIT during sweep ignored
        step(0, 0, 4, 1, 8'h07, 0, 0, 8'h00, 8'h00, 0);
        step(4, 4, 0, 1, 8'h03, 1, 1, 8'h07, 8'h07, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h07, 8'h07, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h07, 8'h07, 1);
        step(4, 4, 5, 1, 8'h0F, 1, 1, 8'h07, 8'h07, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h07, 8'h07, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h0A, 8'h0A, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h0A, 8'h0A, 1);
        step(4, 4, 5, 1, 8'h0F, 0, 1, 8'h0A, 8'h0A, 1);
        step(4, 4, 5, 1, 8'h0F, 1, 1, 8'h0A, 8'h0A, 0);
        step(0, 5, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 0);
        step(1, 2, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 0);
        step(3, 6, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 0);
        step(7, 4, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 0);

        // reset three cycles into a sweep
        step(0, 0, 0, 0, 8'h00, 1, 1, 8'h0A, 8'h0A, 1);
        step(0, 0, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 1);
        step(0, 0, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 1);
        step(0, 0, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 1);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        cmp("midrst_p", 8'hF4, {4'h0, a_datap}, 8'h00);
        cmp("midrst_q", 8'hF5, {4'h0, a_dataq}, 8'h00);
        cmp("midrst_busy", 8'hF6, {7'd0, a_busy}, 8'h00);
        cmp("midrst_state", 8'hF7, {7'd0, a_state}, 8'h00);
        init = 1'b1;
        rp = 3'd3;
        rq = 3'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        expect_out(1, 8'h00, 8'h00, 1);
        for (int i = 0; i < 7; i++) begin
            step(7, 7, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1);
        end
        step(7, 7, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0A, 0);

        // 6-deep, 8-bit instance from a fresh reset
        @(negedge clk);
        clrn = 1'b0;
        init = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        sel = 1'b1;
        step(7, 7, 7, 1, 8'hFF, 0, 1, 8'h00, 8'h00, 0);
        step(7, 5, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0);
        step(0, 0, 5, 1, 8'h3C, 0, 0, 8'h00, 8'h00, 0);
        step(5, 5, 0, 0, 8'h00, 0, 1, 8'h3C, 8'h3C, 0);
        step(5, 0, 0, 0, 8'h00, 1, 1, 8'h3C, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            step(5, 0, 0, 0, 8'h00, 0, 1, 8'h3C, 8'hA5, 1);
        end
        step(5, 0, 0, 0, 8'h00, 0, 1, 8'hA5, 8'hA5, 0);
        step(1, 4, 0, 0, 8'h00, 0, 1, 8'hA5, 8'hA5, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            cmp("queue_drain", 8'hF8, 8'(exp_q.size()), 8'h00);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
